// File: rtl/rx_bit_sampler_if.sv
// rtl/rx_bit_sampler_if.sv - line-side inputs and decoded bit strobes of rx_bit_sampler
// Purpose: bundles the oversample tick, the raw rx line and every strobe the
//   sampler hands to rx_fsm, the shift register and the parity checker.
// Members:
//   sample_tick, rx_in            : into the sampler (master inputs)
//   start_bit_detected, bit_valid,
//   bit_data, parity_valid,
//   parity_bit, frame_done,
//   framing_error, false_start,
//   busy                          : out of the sampler (master outputs)
interface rx_bit_sampler_if;
  logic sample_tick;
  logic rx_in;
  logic start_bit_detected;
  logic bit_valid;
  logic bit_data;
  logic parity_valid;
  logic parity_bit;
  logic frame_done;
  logic framing_error;
  logic false_start;
  logic busy;

  modport master (
    input  sample_tick, rx_in,
    output start_bit_detected, bit_valid, bit_data, parity_valid, parity_bit,
           frame_done, framing_error, false_start, busy
  );

  modport slave (
    output sample_tick, rx_in,
    input  start_bit_detected, bit_valid, bit_data, parity_valid, parity_bit,
           frame_done, framing_error, false_start, busy
  );
endinterface

// File: rtl/rx_bit_sampler.sv
// rtl/rx_bit_sampler.sv - UART receive front end: sync, start detect, mid-bit majority sampling
// Purpose: synchronises rx_in, finds the start-bit falling edge, votes each bit
//   2-of-3 around mid-bit and emits one-cycle strobes per start/data/parity/stop.
// Ports:
//   rx_clk : receiver clock, posedge
//   resetn : synchronous active-low reset
//   bus    : rx_bit_sampler_if.master (sample_tick, rx_in in; strobes, busy out)
module rx_bit_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic             rx_clk,
  input  logic             resetn,
  rx_bit_sampler_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic          rx_prev_q, rx_prev_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [1:0]    samp_q, samp_d;
  logic          vote_q, vote_d;
  logic          vote_valid_q, vote_valid_d;
  logic          bit_data_q, bit_data_d;
  logic          parity_bit_q, parity_bit_d;

  logic fall_edge;
  logic tick_wrap;
  logic majority;
  logic counting;

  always_comb begin
    fall_edge = rx_prev_q & ~rx_s_q;
    tick_wrap = bus.sample_tick && (tick_cnt_q == TICK_LAST);
    // Third sample is taken straight from rx_s so the vote registers on the M+1 tick.
    majority  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    counting  = (state_q != S_IDLE) && (state_q != S_BREAK);

    rx_meta_d    = bus.rx_in;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_idx_d    = bit_idx_q;
    samp_d       = samp_q;
    vote_d       = vote_q;
    vote_valid_d = 1'b0;
    bit_data_d   = bit_data_q;
    parity_bit_d = parity_bit_q;

    if (counting && bus.sample_tick) begin
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == TICK_S0) samp_d[0] = rx_s_q;
      if (tick_cnt_q == TICK_S1) samp_d[1] = rx_s_q;
      if (tick_cnt_q == TICK_S2) begin
        vote_d       = majority;
        vote_valid_d = 1'b1;
        if (state_q == S_DATA)   bit_data_d   = majority;
        if (state_q == S_PARITY) parity_bit_d = majority;
      end
    end

    // Vote-driven decisions act in the cycle the registered vote is visible,
    // so the pulse and the state change line up without extra delay flops.
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (fall_edge) state_d = S_START;
      end
      S_START: begin
        if (vote_valid_q && vote_q) state_d = S_IDLE;
        else if (tick_wrap)         state_d = S_DATA;
      end
      S_DATA: begin
        if (tick_wrap) begin
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave on the vote, not the wrap, so a start bit right after the stop bit is seen.
        if (vote_valid_q) state_d = vote_q ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (!resetn) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      samp_q       <= '0;
      vote_q       <= 1'b0;
      vote_valid_q <= 1'b0;
      bit_data_q   <= 1'b0;
      parity_bit_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_idx_q    <= bit_idx_d;
      samp_q       <= samp_d;
      vote_q       <= vote_d;
      vote_valid_q <= vote_valid_d;
      bit_data_q   <= bit_data_d;
      parity_bit_q <= parity_bit_d;
    end
  end

  assign bus.start_bit_detected = vote_valid_q && (state_q == S_START) && !vote_q;
  assign bus.false_start        = vote_valid_q && (state_q == S_START) && vote_q;
  assign bus.bit_valid          = vote_valid_q && (state_q == S_DATA);
  assign bus.parity_valid       = vote_valid_q && (state_q == S_PARITY);
  assign bus.frame_done         = vote_valid_q && (state_q == S_STOP) && vote_q;
  assign bus.framing_error      = vote_valid_q && (state_q == S_STOP) && !vote_q;
  assign bus.bit_data           = bit_data_q;
  assign bus.parity_bit         = parity_bit_q;
  assign bus.busy               = (state_q != S_IDLE);
endmodule

// File: tb/tb_rx_bit_sampler.sv
// tb/tb_rx_bit_sampler.sv - self-checking bench for rx_bit_sampler (parity and no-parity builds)
module tb_rx_bit_sampler;
  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_BIT   = 3'd2;
  localparam logic [2:0] EV_PAR   = 3'd3;
  localparam logic [2:0] EV_DONE  = 3'd4;
  localparam logic [2:0] EV_FERR  = 3'd5;
  localparam logic [2:0] EV_FALSE = 3'd6;

  logic rx_clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   overlap_cnt = 0;

  logic [3:0] exp_a[$];
  logic [3:0] obs_a[$];
  logic [3:0] exp_b[$];
  logic [3:0] obs_b[$];

  always #5 rx_clk = ~rx_clk;

  rx_bit_sampler_if ifa ();
  rx_bit_sampler_if ifb ();

  rx_bit_sampler #(.OVERSAMPLE(16), .DATA_WIDTH(8), .PARITY_EN(1)) dut_a (
    .rx_clk(rx_clk), .resetn(resetn), .bus(ifa)
  );
  rx_bit_sampler #(.OVERSAMPLE(16), .DATA_WIDTH(8), .PARITY_EN(0)) dut_b (
    .rx_clk(rx_clk), .resetn(resetn), .bus(ifb)
  );

  // Free-running sample tick: one cycle in four.
  initial begin
    ifa.sample_tick = 1'b0;
    ifb.sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge rx_clk);
      ifa.sample_tick = 1'b1;
      ifb.sample_tick = 1'b1;
      @(negedge rx_clk);
      ifa.sample_tick = 1'b0;
      ifb.sample_tick = 1'b0;
    end
  end

  // Observer: logs every strobe as {kind, value}; comparison happens in the tests.
  initial begin
    forever begin
      int na, nb;
      @(negedge rx_clk);
      na = 0; nb = 0;
      if (ifa.start_bit_detected) begin obs_a.push_back({EV_START, 1'b0}); na++; end
      if (ifa.bit_valid)          begin obs_a.push_back({EV_BIT, ifa.bit_data}); na++; end
      if (ifa.parity_valid)       begin obs_a.push_back({EV_PAR, ifa.parity_bit}); na++; end
      if (ifa.frame_done)         begin obs_a.push_back({EV_DONE, 1'b0}); na++; end
      if (ifa.framing_error)      begin obs_a.push_back({EV_FERR, 1'b0}); na++; end
      if (ifa.false_start)        begin obs_a.push_back({EV_FALSE, 1'b0}); na++; end
      if (ifb.start_bit_detected) begin obs_b.push_back({EV_START, 1'b0}); nb++; end
      if (ifb.bit_valid)          begin obs_b.push_back({EV_BIT, ifb.bit_data}); nb++; end
      if (ifb.parity_valid)       begin obs_b.push_back({EV_PAR, ifb.parity_bit}); nb++; end
      if (ifb.frame_done)         begin obs_b.push_back({EV_DONE, 1'b0}); nb++; end
      if (ifb.framing_error)      begin obs_b.push_back({EV_FERR, 1'b0}); nb++; end
      if (ifb.false_start)        begin obs_b.push_back({EV_FALSE, 1'b0}); nb++; end
      if (na > 1 || nb > 1) overlap_cnt++;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge rx_clk);
      while (ifa.sample_tick !== 1'b1) @(posedge rx_clk);
    end
    #1;
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) ifb.rx_in = v;
    else     ifa.rx_in = v;
  endtask

  task automatic push_exp(input bit sel, input logic [3:0] ev);
    if (sel) exp_b.push_back(ev);
    else     exp_a.push_back(ev);
  endtask

  // sel=0 drives the parity build, sel=1 the no-parity build; even parity.
  task automatic send_frame(input bit sel, input logic [7:0] data, input int glitch_bit,
                            input logic stop_val, input int stop_ticks);
    push_exp(sel, {EV_START, 1'b0});
    drive_rx(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      push_exp(sel, {EV_BIT, data[i]});
      drive_rx(sel, data[i]);
      if (i == glitch_bit) begin
        wait_ticks(8);
        drive_rx(sel, ~data[i]);
        wait_ticks(1);
        drive_rx(sel, data[i]);
        wait_ticks(7);
      end else begin
        wait_ticks(16);
      end
    end
    if (!sel) begin
      push_exp(sel, {EV_PAR, ^data});
      drive_rx(sel, ^data);
      wait_ticks(16);
    end
    push_exp(sel, stop_val ? {EV_DONE, 1'b0} : {EV_FERR, 1'b0});
    drive_rx(sel, stop_val);
    wait_ticks(stop_ticks);
  endtask

  task automatic test_reset;
    @(negedge rx_clk);
    checks++; if (ifa.start_bit_detected !== 1'b0) begin failures++; $display("FAIL rst_start: got %b want 0", ifa.start_bit_detected); end
    checks++; if (ifa.bit_valid !== 1'b0)          begin failures++; $display("FAIL rst_bit_valid: got %b want 0", ifa.bit_valid); end
    checks++; if (ifa.bit_data !== 1'b0)           begin failures++; $display("FAIL rst_bit_data: got %b want 0", ifa.bit_data); end
    checks++; if (ifa.parity_valid !== 1'b0)       begin failures++; $display("FAIL rst_parity_valid: got %b want 0", ifa.parity_valid); end
    checks++; if (ifa.parity_bit !== 1'b0)         begin failures++; $display("FAIL rst_parity_bit: got %b want 0", ifa.parity_bit); end
    checks++; if (ifa.frame_done !== 1'b0)         begin failures++; $display("FAIL rst_frame_done: got %b want 0", ifa.frame_done); end
    checks++; if (ifa.framing_error !== 1'b0)      begin failures++; $display("FAIL rst_framing_error: got %b want 0", ifa.framing_error); end
    checks++; if (ifa.false_start !== 1'b0)        begin failures++; $display("FAIL rst_false_start: got %b want 0", ifa.false_start); end
    checks++; if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got a=%b b=%b want 0", ifa.busy, ifb.busy); end
    resetn = 1'b1;
    repeat (8) @(negedge rx_clk);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", ifa.busy); end
  endtask

  task automatic test_frame_a5;
    logic [3:0] e, o;
    send_frame(1'b0, 8'hA5, -1, 1'b1, 16);
    repeat (4) @(negedge rx_clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL a5_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL a5_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL a5_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
    checks++; if (ifa.bit_data !== 1'b1)   begin failures++; $display("FAIL a5_bit_hold: got %b want 1", ifa.bit_data); end
    checks++; if (ifa.parity_bit !== 1'b0) begin failures++; $display("FAIL a5_parity_hold: got %b want 0", ifa.parity_bit); end
  endtask

  task automatic test_false_start;
    logic [3:0] e, o;
    bit found = 1'b0;
    push_exp(1'b0, {EV_FALSE, 1'b0});
    drive_rx(1'b0, 1'b0);
    wait_ticks(3);
    drive_rx(1'b0, 1'b1);
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge rx_clk);
      if (ifa.false_start) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL fs_timeout: got no false_start within 400 cycles want pulse"); end
    else begin
      checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL fs_busy_pulse: got %b want 1", ifa.busy); end
      @(negedge rx_clk);
      checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL fs_busy_drop: got %b want 0", ifa.busy); end
    end
    wait_ticks(16);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL fs_events: got none want kind=%0d", e[3:1]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL fs_events: got kind=%0d want kind=%0d", o[3:1], e[3:1]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL fs_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_glitch;
    logic [3:0] e, o;
    send_frame(1'b0, 8'h00, 3, 1'b1, 16);
    repeat (4) @(negedge rx_clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL glitch_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL glitch_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL glitch_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_framing_error;
    logic [3:0] e, o;
    bit dropped = 1'b0;
    send_frame(1'b0, 8'h5A, -1, 1'b0, 40);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_hold: got %b want 1", ifa.busy); end
    drive_rx(1'b0, 1'b1);
    for (int i = 0; i < 20 && !dropped; i++) begin
      @(negedge rx_clk);
      if (ifa.busy === 1'b0) dropped = 1'b1;
    end
    checks++; if (!dropped) begin failures++; $display("FAIL ferr_busy_release: got busy=%b after 20 cycles want 0", ifa.busy); end
    wait_ticks(16);
    send_frame(1'b0, 8'h81, -1, 1'b1, 16);
    repeat (4) @(negedge rx_clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL ferr_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL ferr_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL ferr_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] e, o;
    logic [7:0] d;
    d = 8'h96;
    push_exp(1'b0, {EV_START, 1'b0});
    drive_rx(1'b0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, {EV_BIT, d[i]});
      drive_rx(1'b0, d[i]);
      wait_ticks(16);
    end
    drive_rx(1'b0, d[4]);
    wait_ticks(8);
    @(negedge rx_clk);
    resetn = 1'b0;
    @(negedge rx_clk);
    checks++;
    if ({ifa.start_bit_detected, ifa.bit_valid, ifa.bit_data, ifa.parity_valid, ifa.parity_bit,
         ifa.frame_done, ifa.framing_error, ifa.false_start, ifa.busy} !== 9'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got busy=%b bit_valid=%b bit_data=%b want all 0", ifa.busy, ifa.bit_valid, ifa.bit_data);
    end
    resetn = 1'b1;
    drive_rx(1'b0, 1'b1);
    wait_ticks(80);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL midrst_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL midrst_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL midrst_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
    send_frame(1'b0, 8'h97, -1, 1'b1, 16);
    repeat (4) @(negedge rx_clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL postrst_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL postrst_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL postrst_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e, o;
    send_frame(1'b0, 8'h3C, -1, 1'b1, 16);
    send_frame(1'b0, 8'hC3, -1, 1'b1, 16);
    repeat (4) @(negedge rx_clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); checks++;
      if (obs_a.size() == 0) begin failures++; $display("FAIL b2b_par_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_a.pop_front(); if (o !== e) begin failures++; $display("FAIL b2b_par_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_a.size() != 0) begin failures++; $display("FAIL b2b_par_extra: got %0d extra events want 0", obs_a.size()); obs_a.delete(); end
    send_frame(1'b1, 8'h3C, -1, 1'b1, 16);
    send_frame(1'b1, 8'hC3, -1, 1'b1, 16);
    repeat (4) @(negedge rx_clk);
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front(); checks++;
      if (obs_b.size() == 0) begin failures++; $display("FAIL b2b_nopar_events: got none want kind=%0d val=%0b", e[3:1], e[0]); end
      else begin o = obs_b.pop_front(); if (o !== e) begin failures++; $display("FAIL b2b_nopar_events: got kind=%0d val=%0b want kind=%0d val=%0b", o[3:1], o[0], e[3:1], e[0]); end end
    end
    checks++; if (obs_b.size() != 0) begin failures++; $display("FAIL b2b_nopar_extra: got %0d extra events want 0", obs_b.size()); obs_b.delete(); end
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL pulse_overlap: got %0d overlapping cycles want 0", overlap_cnt); end
  endtask

  initial begin
    ifa.rx_in = 1'b1;
    ifb.rx_in = 1'b1;
    resetn    = 1'b0;
    repeat (4) @(negedge rx_clk);
    test_reset();
    test_frame_a5();
    test_false_start();
    test_glitch();
    test_framing_error();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
